// File: rtl/gfg_pkg.sv
// Shared graphics-pipeline definitions: FSM encoding, default frame geometry,
// pixel colour field layout and small elaboration-time helpers.
package gfg_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_DRAW  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int HRES_DEF        = 80;
  localparam int VRES_DEF        = 60;
  localparam int COLOR_DEPTH_DEF = 12;

  // 12-bit pixel layout R[11:8] G[7:4] B[3:0]
  localparam int R_OFS = 8;
  localparam int G_OFS = 4;
  localparam int B_OFS = 0;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bresenham_step.sv
// One combinational Bresenham step: both axis updates derive from the same e2.
module bresenham_step #(
  parameter int XW = 7,
  parameter int YW = 6,
  parameter int W  = 10
) (
  input  logic [XW-1:0]       cur_x,
  input  logic [YW-1:0]       cur_y,
  input  logic signed [W-1:0] err,
  input  logic signed [W-1:0] dx,
  input  logic signed [W-1:0] dy,
  input  logic                sx_neg,
  input  logic                sy_neg,
  output logic [XW-1:0]       nxt_x,
  output logic [YW-1:0]       nxt_y,
  output logic signed [W-1:0] nxt_err
);

  logic signed [W-1:0] e2;

  always_comb begin
    e2      = err <<< 1;
    nxt_err = err;
    nxt_x   = cur_x;
    nxt_y   = cur_y;
    if (e2 >= dy) begin
      nxt_err = nxt_err + dy;
      nxt_x   = sx_neg ? cur_x - XW'(1) : cur_x + XW'(1);
    end
    if (e2 <= dx) begin
      nxt_err = nxt_err + dx;
      nxt_y   = sy_neg ? cur_y - YW'(1) : cur_y + YW'(1);
    end
  end

endmodule

// File: rtl/line_rasterizer.sv
// Solid-colour line drawer: one Bresenham pixel per cycle into the frame
// buffer rasterizer write port, with go/busy/done/error command handshake.
module line_rasterizer
  import gfg_pkg::*;
#(
  parameter int HORIZ_RESOLUTION = HRES_DEF,
  parameter int VERT_RESOLUTION  = VRES_DEF,
  parameter int COLOR_DEPTH      = COLOR_DEPTH_DEF,
  localparam int XW = $clog2(HORIZ_RESOLUTION),
  localparam int YW = $clog2(VERT_RESOLUTION)
) (
  input  logic                   i_clk,
  input  logic                   i_srst,
  input  logic                   i_go,
  input  logic [XW-1:0]          i_x0,
  input  logic [XW-1:0]          i_x1,
  input  logic [YW-1:0]          i_y0,
  input  logic [YW-1:0]          i_y1,
  input  logic [COLOR_DEPTH-1:0] i_color,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_error,
  output logic [XW-1:0]          o_horiz_write_addr,
  output logic [YW-1:0]          o_vert_write_addr,
  output logic                   o_write_en,
  output logic [COLOR_DEPTH-1:0] o_write_pixel_data
);

  localparam int W = max2(XW, YW) + 3;
  localparam logic [XW-1:0] XMAX = XW'(HORIZ_RESOLUTION - 1);
  localparam logic [YW-1:0] YMAX = YW'(VERT_RESOLUTION - 1);

  logic [1:0]             state;
  logic [XW-1:0]          x0_q, x1_q, cur_x, nxt_x;
  logic [YW-1:0]          y0_q, y1_q, cur_y, nxt_y;
  logic [COLOR_DEPTH-1:0] color_q;
  logic signed [W-1:0]    dx_q, dy_q, err_q, nxt_err;
  logic                   sx_neg, sy_neg;

  logic signed [W-1:0] x0s, x1s, y0s, y1s, dx_c, dy_c;
  logic                sxn_c, syn_c, go_bad, at_end;

  assign go_bad = (i_x0 > XMAX) || (i_x1 > XMAX) || (i_y0 > YMAX) || (i_y1 > YMAX);
  assign at_end = (cur_x == x1_q) && (cur_y == y1_q);

  // Zero-extend coordinates so the signed differences cannot wrap
  assign x0s   = $signed({{(W-XW){1'b0}}, x0_q});
  assign x1s   = $signed({{(W-XW){1'b0}}, x1_q});
  assign y0s   = $signed({{(W-YW){1'b0}}, y0_q});
  assign y1s   = $signed({{(W-YW){1'b0}}, y1_q});
  assign sxn_c = x1_q < x0_q;
  assign syn_c = y1_q < y0_q;
  assign dx_c  = sxn_c ? (x0s - x1s) : (x1s - x0s);
  assign dy_c  = syn_c ? (y1s - y0s) : (y0s - y1s);

  bresenham_step #(.XW(XW), .YW(YW), .W(W)) u_step (
    .cur_x   (cur_x),
    .cur_y   (cur_y),
    .err     (err_q),
    .dx      (dx_q),
    .dy      (dy_q),
    .sx_neg  (sx_neg),
    .sy_neg  (sy_neg),
    .nxt_x   (nxt_x),
    .nxt_y   (nxt_y),
    .nxt_err (nxt_err)
  );

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state              <= ST_IDLE;
      o_busy             <= 1'b0;
      o_done             <= 1'b0;
      o_error            <= 1'b0;
      o_write_en         <= 1'b0;
      o_horiz_write_addr <= '0;
      o_vert_write_addr  <= '0;
      o_write_pixel_data <= '0;
      x0_q <= '0; x1_q <= '0; y0_q <= '0; y1_q <= '0;
      cur_x <= '0; cur_y <= '0; color_q <= '0;
      dx_q <= '0; dy_q <= '0; err_q <= '0;
      sx_neg <= 1'b0; sy_neg <= 1'b0;
    end else begin
      o_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          // The error pulse cycle doubles as the turnaround after a reject
          if (i_go && !o_error) begin
            x0_q <= i_x0; x1_q <= i_x1; y0_q <= i_y0; y1_q <= i_y1;
            color_q <= i_color;
            if (go_bad) begin
              o_error <= 1'b1;
            end else begin
              state  <= ST_SETUP;
              o_busy <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          dx_q   <= dx_c;
          dy_q   <= dy_c;
          err_q  <= dx_c + dy_c;
          sx_neg <= sxn_c;
          sy_neg <= syn_c;
          cur_x  <= x0_q;
          cur_y  <= y0_q;
          o_horiz_write_addr <= x0_q;
          o_vert_write_addr  <= y0_q;
          o_write_pixel_data <= color_q;
          o_write_en         <= 1'b1;
          state              <= ST_DRAW;
        end
        ST_DRAW: begin
          // cur always mirrors the pixel currently presented on the port
          if (at_end) begin
            o_write_en <= 1'b0;
            o_done     <= 1'b1;
            state      <= ST_DONE;
          end else begin
            cur_x <= nxt_x;
            cur_y <= nxt_y;
            err_q <= nxt_err;
            o_horiz_write_addr <= nxt_x;
            o_vert_write_addr  <= nxt_y;
          end
        end
        ST_DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
